// File: rtl/uart_rx_word_packer.sv
// UART 8N1 receiver that packs bytes into WORD_BYTES-wide AXI-Stream words, first byte in the MSBs.
// Define UART_RX_TIMEOUT_EN to discard a partial word after TIMEOUT_BITS idle bit-times.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for a synced falling edge
// START   | half a bit into the start bit; confirm low or reject glitch
// DATA    | sampling 8 data bits at bit centre, LSB first
// STOP    | sampling stop bit; high = byte good, low = framing error
// BREAK   | framing error seen; wait for the line to return high
module uart_rx_word_packer #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int OVERSAMPLE   = 16,
    parameter int WORD_BYTES   = 8,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RsRx,
    output logic [8*WORD_BYTES-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    frame_err,
    output logic                    overrun
);

    localparam int TW    = 8 * WORD_BYTES;
    localparam int SW    = TW - 8;
    localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_FULL  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_BYTES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [1:0]       rst_sync;
    logic             rst_int_n;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic             start_edge;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [2:0]       state;
    logic [OS_W-1:0]  os_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             sample_evt;
    logic             byte_done;
    logic [SW-1:0]    sr;
    logic [CNT_W-1:0] byte_cnt;
    logic             flush;

    // Assert passes straight through; release is delayed two clocks to stay synchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RsRx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == S_IDLE) && rx_prev && !rx_sync;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)                   div_cnt <= DIV_LAST;
        else if (start_edge)              div_cnt <= DIV_LAST;
        else if (div_cnt == DIV_W'(0))    div_cnt <= DIV_LAST;
        else                              div_cnt <= div_cnt - DIV_W'(1);
    end
    assign tick = (div_cnt == DIV_W'(0));

    assign sample_evt = tick && (os_cnt == OS_W'(0));
    assign byte_done  = (state == S_STOP) && sample_evt && rx_sync;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state     <= S_IDLE;
            os_cnt    <= OS_HALF;
            bit_idx   <= 3'd0;
            rx_byte   <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state  <= S_START;
                        os_cnt <= OS_HALF;
                    end
                end
                S_START: begin
                    if (sample_evt) begin
                        os_cnt  <= OS_FULL;
                        bit_idx <= 3'd0;
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else if (tick) begin
                        os_cnt <= os_cnt - OS_W'(1);
                    end
                end
                S_DATA: begin
                    if (sample_evt) begin
                        rx_byte <= {rx_sync, rx_byte[7:1]};
                        os_cnt  <= OS_FULL;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else if (tick) begin
                        os_cnt <= os_cnt - OS_W'(1);
                    end
                end
                S_STOP: begin
                    if (sample_evt) begin
                        if (rx_sync) begin
                            state <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else if (tick) begin
                        os_cnt <= os_cnt - OS_W'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_sync) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int IB_W = $clog2(TIMEOUT_BITS + 1);

    logic [OS_W-1:0] idle_os;
    logic [IB_W-1:0] idle_bits;

    // Counts whole bit-times of idle line; saturates at zero once the timeout has fired.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            idle_os   <= OS_FULL;
            idle_bits <= IB_W'(TIMEOUT_BITS);
        end else if (state != S_IDLE || start_edge) begin
            idle_os   <= OS_FULL;
            idle_bits <= IB_W'(TIMEOUT_BITS);
        end else if (tick) begin
            if (idle_os == OS_W'(0)) begin
                idle_os <= OS_FULL;
                if (idle_bits != IB_W'(0)) idle_bits <= idle_bits - IB_W'(1);
            end else begin
                idle_os <= idle_os - OS_W'(1);
            end
        end
    end

    assign flush = (state == S_IDLE) && !start_edge && tick && (idle_os == OS_W'(0)) &&
                   (idle_bits == IB_W'(1)) && (byte_cnt != CNT_W'(0));
`else
    assign flush = 1'b0;
`endif

    // The receiver never stalls: a completed word with the output still held is dropped.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sr            <= '0;
            byte_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
            if (byte_done) begin
                if (byte_cnt == CNT_LAST) begin
                    byte_cnt <= '0;
                    sr       <= '0;
                    if (!m_axis_tvalid || m_axis_tready) begin
                        m_axis_tdata  <= {sr, rx_byte};
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    sr       <= SW'({sr, rx_byte});
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end else if (flush) begin
                sr       <= '0;
                byte_cnt <= '0;
            end
        end
    end

endmodule
